// File: rtl/handshake_ctrl_arbiter.sv
// Round-robin arbiter forwarding one dataless token per transfer, tagged with the winner index.
// Latency 1 cycle via a one-entry output slot; while the slot is full and stalled, all ins_ready are 0.
module handshake_ctrl_arbiter #(
  parameter int NUM_INPUTS  = 4,
  parameter int INDEX_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_INPUTS-1:0]  ins_valid,
  output logic [NUM_INPUTS-1:0]  ins_ready,
  output logic                   outs_valid,
  input  logic                   outs_ready,
  output logic [INDEX_WIDTH-1:0] outs_index
);

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_INPUTS - 1);

  logic                   full;
  logic [INDEX_WIDTH-1:0] idx_q;
  logic [INDEX_WIDTH-1:0] ptr;

  logic                   load_en;
  logic                   grant_vld;
  logic [INDEX_WIDTH-1:0] grant_idx;
  logic                   in_xfer;
  logic [INDEX_WIDTH-1:0] next_ptr;

  assign load_en = !full || outs_ready;

  // Lowest valid index overall is the fallback; the lowest valid index at or
  // above ptr overrides it, which yields a wrapping scan starting at ptr.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (ins_valid[i]) begin
        grant_vld = 1'b1;
        grant_idx = INDEX_WIDTH'(i);
      end
    end
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (ins_valid[i] && (INDEX_WIDTH'(i) >= ptr)) begin
        grant_idx = INDEX_WIDTH'(i);
      end
    end
  end

  always_comb begin
    ins_ready = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      ins_ready[i] = rst && load_en && grant_vld && (grant_idx == INDEX_WIDTH'(i));
    end
  end

  assign in_xfer  = load_en && grant_vld;
  assign next_ptr = (grant_idx == LAST_IDX) ? '0 : grant_idx + INDEX_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      full  <= 1'b0;
      idx_q <= '0;
      ptr   <= '0;
    end else if (load_en) begin
      if (in_xfer) begin
        full  <= 1'b1;
        idx_q <= grant_idx;
        ptr   <= next_ptr;
      end else begin
        full  <= 1'b0;
      end
    end
  end

  assign outs_valid = full;
  assign outs_index = idx_q;

  ptr_in_range: assert property (@(posedge clk) disable iff (!rst) (ptr <= LAST_IDX && idx_q <= LAST_IDX));
  ready_onehot: assert property (@(posedge clk) $onehot0(ins_ready));

endmodule

// File: tb/tb_handshake_ctrl_arbiter.sv
module tb_handshake_ctrl_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] vin;
  logic [3:0] ins_ready;
  logic       outs_valid;
  logic       ordy;
  logic [1:0] outs_index;

  logic       rst3;
  logic [2:0] v3;
  logic [2:0] rdy3;
  logic       ov3;
  logic       or3;
  logic [1:0] oi3;

  int checks   = 0;
  int failures = 0;

  // Reference model state for the 4-input instance
  int m_full;
  int m_idx;
  int m_ptr;

  always #5 clk = ~clk;

  handshake_ctrl_arbiter #(.NUM_INPUTS(4), .INDEX_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .ins_valid(vin), .ins_ready(ins_ready),
    .outs_valid(outs_valid), .outs_ready(ordy), .outs_index(outs_index)
  );

  handshake_ctrl_arbiter #(.NUM_INPUTS(3), .INDEX_WIDTH(2)) dut3 (
    .clk(clk), .rst(rst3), .ins_valid(v3), .ins_ready(rdy3),
    .outs_valid(ov3), .outs_ready(or3), .outs_index(oi3)
  );

  function automatic int model_grant(input logic [3:0] v);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_ptr + k) % 4;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_ready();
    int g;
    logic [3:0] r;
    r = 4'b0000;
    g = model_grant(vin);
    if (rst && (m_full == 0 || ordy) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  // Advance the model with the currently driven inputs, then clock the DUTs.
  task automatic adv();
    int g;
    if (!rst) begin
      m_full = 0; m_idx = 0; m_ptr = 0;
    end else if (m_full == 0 || ordy) begin
      g = model_grant(vin);
      if (g >= 0) begin
        m_full = 1; m_idx = g; m_ptr = (g + 1) % 4;
      end else begin
        m_full = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; vin = 4'b0000; ordy = 1'b0;
    adv();
    adv();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; vin = 4'b1111; ordy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      adv();
      checks++;
      if (ins_ready !== 4'b0000 || outs_valid !== 1'b0 || outs_index !== 2'd0) begin
        failures++;
        $display("FAIL reset_state cyc=%0d got ready=%b valid=%b index=%0d exp 0000/0/0", c, ins_ready, outs_valid, outs_index);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ins_ready !== 4'b0001) begin
      failures++;
      $display("FAIL reset_first_ready got=%b exp=0001", ins_ready);
    end
    adv();
    checks++;
    if (outs_valid !== 1'b1 || outs_index !== 2'd0) begin
      failures++;
      $display("FAIL reset_first_grant got valid=%b index=%0d exp 1/0", outs_valid, outs_index);
    end
  endtask

  task automatic test_rr_saturation();
    logic [1:0] e;
    do_reset();
    vin = 4'b1111; ordy = 1'b1;
    #1;
    checks++;
    if (outs_valid !== 1'b0 || ins_ready !== 4'b0001) begin
      failures++;
      $display("FAIL sat_start got valid=%b ready=%b exp 0/0001", outs_valid, ins_ready);
    end
    for (int k = 0; k < 8; k++) begin
      adv();
      e = 2'(k % 4);
      checks++;
      if (outs_valid !== 1'b1 || outs_index !== e) begin
        failures++;
        $display("FAIL sat_seq k=%0d got valid=%b index=%0d exp 1/%0d", k, outs_valid, outs_index, e);
      end
      checks++;
      if (ins_ready !== model_ready()) begin
        failures++;
        $display("FAIL sat_ready k=%0d got=%b exp=%b", k, ins_ready, model_ready());
      end
    end
  endtask

  task automatic test_sparse();
    logic [3:0] er;
    do_reset();
    vin = 4'b1010; ordy = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      er = (k % 2 == 0) ? 4'b0010 : 4'b1000;
      checks++;
      if (ins_ready !== er || ins_ready[0] !== 1'b0 || ins_ready[2] !== 1'b0) begin
        failures++;
        $display("FAIL sparse_ready k=%0d got=%b exp=%b", k, ins_ready, er);
      end
      adv();
      checks++;
      if (outs_index !== ((k % 2 == 0) ? 2'd1 : 2'd3)) begin
        failures++;
        $display("FAIL sparse_grant k=%0d got=%0d exp=%0d", k, outs_index, (k % 2 == 0) ? 1 : 3);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    vin = 4'b0100; ordy = 1'b1;
    #1;
    adv();
    vin = 4'b1111; ordy = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (outs_valid !== 1'b1 || outs_index !== 2'd2 || ins_ready !== 4'b0000) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got valid=%b index=%0d ready=%b exp 1/2/0000", c, outs_valid, outs_index, ins_ready);
      end
      adv();
    end
    ordy = 1'b1;
    #1;
    checks++;
    if (ins_ready !== 4'b1000) begin
      failures++;
      $display("FAIL bp_release_ready got=%b exp=1000", ins_ready);
    end
    adv();
    checks++;
    if (outs_valid !== 1'b1 || outs_index !== 2'd3) begin
      failures++;
      $display("FAIL bp_reload got valid=%b index=%0d exp 1/3", outs_valid, outs_index);
    end
  endtask

  task automatic test_non_pow2();
    logic [1:0] e;
    rst3 = 1'b0; v3 = 3'b000; or3 = 1'b1;
    adv();
    rst3 = 1'b1; v3 = 3'b111;
    #1;
    for (int k = 0; k < 4; k++) begin
      e = 2'(k % 3);
      checks++;
      if (rdy3 !== (3'b001 << e)) begin
        failures++;
        $display("FAIL np2_ready k=%0d got=%b exp_index=%0d", k, rdy3, e);
      end
      adv();
      checks++;
      if (ov3 !== 1'b1 || oi3 !== e) begin
        failures++;
        $display("FAIL np2_grant k=%0d got valid=%b index=%0d exp 1/%0d", k, ov3, oi3, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    vin = 4'b1000; ordy = 1'b1;
    #1;
    adv();
    checks++;
    if (outs_valid !== 1'b1 || outs_index !== 2'd3) begin
      failures++;
      $display("FAIL mid_fill got valid=%b index=%0d exp 1/3", outs_valid, outs_index);
    end
    ordy = 1'b0; rst = 1'b0; vin = 4'b0110;
    #1;
    adv();
    checks++;
    if (outs_valid !== 1'b0 || ins_ready !== 4'b0000) begin
      failures++;
      $display("FAIL mid_discard got valid=%b ready=%b exp 0/0000", outs_valid, ins_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ins_ready !== 4'b0010) begin
      failures++;
      $display("FAIL mid_restart_ready got=%b exp=0010", ins_ready);
    end
    adv();
    checks++;
    if (outs_valid !== 1'b1 || outs_index !== 2'd1) begin
      failures++;
      $display("FAIL mid_restart_grant got valid=%b index=%0d exp 1/1", outs_valid, outs_index);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      vin  = 4'($urandom_range(0, 15));
      ordy = ($urandom_range(0, 3) != 0);
      rst  = ($urandom_range(0, 40) != 0);
      #1;
      checks++;
      if (ins_ready !== model_ready()) begin
        failures++;
        $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, ins_ready, model_ready());
      end
      checks++;
      if (outs_valid !== (m_full != 0) || outs_index !== 2'(m_idx)) begin
        failures++;
        $display("FAIL rand_out cyc=%0d got valid=%b index=%0d exp %0d/%0d", c, outs_valid, outs_index, m_full, m_idx);
      end
      adv();
    end
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; vin = 4'b0000; ordy = 1'b0;
    rst3 = 1'b0; v3 = 3'b000; or3 = 1'b0;
    m_full = 0; m_idx = 0; m_ptr = 0;
    test_reset();
    test_rr_saturation();
    test_sparse();
    test_backpressure();
    test_non_pow2();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
